// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path:
// states, opcodes, ALU operations and datapath selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } opclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_PC4  = 2'd0;
  localparam logic [1:0] PC_ALU  = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic [3:0] alu_fn(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: instruction fields to class, ALU op and
// legality flag for the control FSM.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output opclass_e   cls,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    cls    = C_BAD;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    unique case (1'b1)
      (opcode == OP_R): begin
        cls    = C_R;
        alu_op = alu_fn(funct3, funct7b5);
      end
      (opcode == OP_IALU): begin
        cls    = C_IALU;
        // only SRAI uses bit 30; ADDI must never become SUB
        alu_op = alu_fn(funct3,
                        funct7b5 && (funct3 == 3'b101));
      end
      (opcode == OP_LOAD):   cls = C_LOAD;
      (opcode == OP_STORE):  cls = C_STORE;
      (opcode == OP_BRANCH): cls = C_BRANCH;
      (opcode == OP_JAL):    cls = C_JAL;
      (opcode == OP_JALR):   cls = C_JALR;
      (opcode == OP_LUI):    cls = C_LUI;
      (opcode == OP_AUIPC):  cls = C_AUIPC;
      default:               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core, with memory
// watchdog, sticky trap flags and retired-instruction counter.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 br_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [3:0]           alu_op,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WDW =
    (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [WDW-1:0]       wd_q, wd_d;

  opclass_e   cls;
  logic [3:0] dec_alu_op;
  logic       legal;
  logic       retire;
  logic       waiting;
  logic       wd_hit;
  logic       unused_inst;

  assign unused_inst = ^{inst[31], inst[29:15]};

  mc_op_decode u_dec (
    .opcode   (inst[6:0]),
    .funct3   (inst[14:12]),
    .funct7b5 (inst[30]),
    .cls      (cls),
    .alu_op   (dec_alu_op),
    .legal    (legal)
  );

  assign wd_hit = (MEM_WAIT_MAX != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    waiting      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PC4;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (wd_hit) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op = dec_alu_op;
        unique case (cls)
          C_R: state_d = S_WB;
          C_IALU: begin
            alu_b_sel = B_IMM;
            state_d   = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_b_sel = B_IMM;
            state_d   = S_MEM;
          end
          C_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = B_IMM;
            state_d   = S_WB;
          end
          C_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
            state_d   = S_WB;
          end
          C_BRANCH: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_ALU : PC_PC4;
            state_d   = S_FETCH;
            retire    = 1'b1;
          end
          C_JAL: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_sel    = PC_ALU;
            reg_we    = 1'b1;
            wb_sel    = WB_PC4;
            state_d   = S_FETCH;
            retire    = 1'b1;
          end
          C_JALR: begin
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_sel    = PC_JALR;
            reg_we    = 1'b1;
            wb_sel    = WB_PC4;
            state_d   = S_FETCH;
            retire    = 1'b1;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        alu_b_sel    = B_IMM;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else begin
          waiting = 1'b1;
          if (wd_hit) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (cls == C_LOAD) ? WB_MEM : WB_ALU;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // x0 is never written
    if (inst[11:7] == 5'd0) reg_we = 1'b0;
  end

  always_comb begin
    wd_d = '0;
    if (waiting && (state_d == state_q)) wd_d = wd_q + 1'b1;
    instret_d = instret_q
              + {{(INSTRET_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
      wd_q      <= wd_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state_o = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table
// plus trap, watchdog and async-reset sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_sel, alu_a_sel, alu_b_sel, wb_sel;
  logic [3:0]  alu_op;
  logic        reg_we, illegal, timeout;
  logic [2:0]  state_o;
  logic [31:0] instret;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0040A103;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JALR = 32'h00008067;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D293;
  localparam logic [31:0] I_LUI  = 32'h12345237;
  localparam logic [31:0] I_SW   = 32'h0020A423;

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        we;
    logic        asel;
    logic        irwe;
    logic        pcwe;
    logic [1:0]  pcsel;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [3:0]  op;
    logic        rwe;
    logic [1:0]  wb;
    logic        ill;
    logic        to;
    logic [31:0] ir;
  } outs_t;

  typedef struct {
    logic [31:0] inst;
    logic        br;
    logic        mr;
    outs_t       exp;
  } vec_t;

  vec_t tbl[$];

  multicycle_ctrl #(.MEM_WAIT_MAX(16), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .inst(inst),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .illegal(illegal), .timeout(timeout),
    .state_o(state_o), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(
    int st, int req, int we, int asel, int irwe,
    int pcwe, int pcsel, int a, int b, int op,
    int rwe, int wb, int ir
  );
    outs_t o;
    o.st = 3'(st);   o.req = 1'(req);  o.we = 1'(we);
    o.asel = 1'(asel); o.irwe = 1'(irwe);
    o.pcwe = 1'(pcwe); o.pcsel = 2'(pcsel);
    o.a = 2'(a);     o.b = 2'(b);      o.op = 4'(op);
    o.rwe = 1'(rwe); o.wb = 2'(wb);
    o.ill = 1'b0;    o.to = 1'b0;      o.ir = 32'(ir);
    return o;
  endfunction

  function automatic outs_t fe(int ir, int mr);
    return mk(1, 1, 0, 0, mr, 0, 0, 0, 0, 0, 0, 0, ir);
  endfunction

  function automatic outs_t dc(int ir);
    return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir);
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o.st = state_o; o.req = mem_req; o.we = mem_we;
    o.asel = mem_addr_sel; o.irwe = ir_we;
    o.pcwe = pc_we; o.pcsel = pc_sel;
    o.a = alu_a_sel; o.b = alu_b_sel; o.op = alu_op;
    o.rwe = reg_we; o.wb = wb_sel;
    o.ill = illegal; o.to = timeout; o.ir = instret;
    return o;
  endfunction

  task automatic add(
    logic [31:0] i, logic br, logic mr, outs_t e
  );
    vec_t v;
    v.inst = i; v.br = br; v.mr = mr; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, outs_t act, outs_t exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic [31:0] act,
                      logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    outs_t e;
    rst = 1'b1; inst = '0; br_taken = 1'b0; mem_ready = 1'b0;

    add(I_ADDI, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(I_ADDI, 0, 1, fe(0, 1));
    add(I_ADDI, 0, 1, dc(0));
    add(I_ADDI, 0, 1, mk(3,0,0,0,0,0,0,0,1,0,0,0,0));
    add(I_ADDI, 0, 1, mk(5,0,0,0,0,1,0,0,0,0,1,0,0));
    add(I_LW, 0, 0, fe(1, 0));
    add(I_LW, 0, 0, fe(1, 0));
    add(I_LW, 0, 0, fe(1, 0));
    add(I_LW, 0, 1, fe(1, 1));
    add(I_LW, 0, 1, dc(1));
    add(I_LW, 0, 1, mk(3,0,0,0,0,0,0,0,1,0,0,0,1));
    add(I_LW, 0, 0, mk(4,1,0,1,0,0,0,0,1,0,0,0,1));
    add(I_LW, 0, 0, mk(4,1,0,1,0,0,0,0,1,0,0,0,1));
    add(I_LW, 0, 0, mk(4,1,0,1,0,0,0,0,1,0,0,0,1));
    add(I_LW, 0, 1, mk(4,1,0,1,0,0,0,0,1,0,0,0,1));
    add(I_LW, 0, 1, mk(5,0,0,0,0,1,0,0,0,0,1,1,1));
    add(I_BEQ, 1, 1, fe(2, 1));
    add(I_BEQ, 1, 1, dc(2));
    add(I_BEQ, 1, 1, mk(3,0,0,0,0,1,1,1,1,0,0,0,2));
    add(I_BEQ, 0, 1, fe(3, 1));
    add(I_BEQ, 0, 1, dc(3));
    add(I_BEQ, 0, 1, mk(3,0,0,0,0,1,0,1,1,0,0,0,3));
    add(I_JALR, 0, 1, fe(4, 1));
    add(I_JALR, 0, 1, dc(4));
    add(I_JALR, 0, 1, mk(3,0,0,0,0,1,2,0,1,0,0,2,4));
    add(I_JAL, 0, 1, fe(5, 1));
    add(I_JAL, 0, 1, dc(5));
    add(I_JAL, 0, 1, mk(3,0,0,0,0,1,1,1,1,0,1,2,5));
    add(I_SUB, 0, 1, fe(6, 1));
    add(I_SUB, 0, 1, dc(6));
    add(I_SUB, 0, 1, mk(3,0,0,0,0,0,0,0,0,1,0,0,6));
    add(I_SUB, 0, 1, mk(5,0,0,0,0,1,0,0,0,0,1,0,6));
    add(I_SRAI, 0, 1, fe(7, 1));
    add(I_SRAI, 0, 1, dc(7));
    add(I_SRAI, 0, 1, mk(3,0,0,0,0,0,0,0,1,7,0,0,7));
    add(I_SRAI, 0, 1, mk(5,0,0,0,0,1,0,0,0,0,1,0,7));
    add(I_LUI, 0, 1, fe(8, 1));
    add(I_LUI, 0, 1, dc(8));
    add(I_LUI, 0, 1, mk(3,0,0,0,0,0,0,2,1,0,0,0,8));
    add(I_LUI, 0, 1, mk(5,0,0,0,0,1,0,0,0,0,1,0,8));
    add(I_SW, 0, 1, fe(9, 1));
    add(I_SW, 0, 1, dc(9));
    add(I_SW, 0, 1, mk(3,0,0,0,0,0,0,0,1,0,0,0,9));
    add(I_SW, 0, 1, mk(4,1,1,1,0,1,0,0,1,0,0,0,9));
    add(I_ADDI, 0, 0, fe(10, 0));

    do_reset();
    foreach (tbl[i]) begin
      inst = tbl[i].inst;
      br_taken = tbl[i].br;
      mem_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), cur(), tbl[i].exp);
      step();
    end

    // illegal opcode: trap is terminal and quiet
    do_reset();
    inst = 32'h0; mem_ready = 1'b1; br_taken = 1'b0;
    step(); step(); step();
    e = mk(6,0,0,0,0,0,0,0,0,0,0,0,0);
    e.ill = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_ready = k[0];
      #1;
      chk($sformatf("trap_ill%0d", k), cur(), e);
      step();
    end
    do_reset();
    chk("ill_clear", cur(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // watchdog expires on the 16th idle fetch cycle
    mem_ready = 1'b0; inst = I_ADDI;
    step();
    repeat (15) step();
    chk1("wd_hold15", {29'd0, state_o}, 32'd1);
    step();
    e = mk(6,0,0,0,0,0,0,0,0,0,0,0,0);
    e.to = 1'b1;
    chk("wd_trap", cur(), e);

    // ready on the 16th cycle wins over the watchdog
    do_reset();
    mem_ready = 1'b0;
    step();
    repeat (15) step();
    mem_ready = 1'b1;
    step();
    chk("wd_race", cur(), dc(0));

    // async reset in MEM of a store drops the request at once
    do_reset();
    inst = I_SUB; mem_ready = 1'b1;
    repeat (5) step();
    chk1("sub_retired", instret, 32'd1);
    inst = I_SW;
    repeat (3) step();
    mem_ready = 1'b0;
    #1;
    chk("sw_in_mem", cur(),
        mk(4,1,1,1,0,0,0,0,1,0,0,0,1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem", cur(),
        mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b0;
    step();
    chk1("after_rst", {29'd0, state_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
